// File: rtl/gate_exerciser3.sv
`default_nettype none
// ============================================================================
//  Module      : gate_exerciser3
//  Description : Sequential stimulus/checker for a 3-input, 1-output gate.
//                Walks x2..x0 through all 8 input vectors, holds each one
//                for SETTLE_CYCLES+1 clocks, and samples the synchronised
//                gate response. Each response is compared against the
//                EXPECT_MASK truth table.
//                Optional macro GATE_EX_CONTINUE_EN: mismatches do not stop
//                the run, and err_mask records every failing vector.
//  Revision    : 1.0  initial release
// ============================================================================
module gate_exerciser3 #(
    parameter int unsigned SETTLE_CYCLES = 32'd12000000,
    parameter logic [7:0]  EXPECT_MASK   = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       x0,
    output logic       x1,
    output logic       x2,
    input  logic       z0,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] vec_idx,
    output logic [2:0] fail_idx,
    output logic [7:0] err_mask
);

    localparam int unsigned c_cnt_w = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_SAMPLE = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [2:0]         vec_q, vec_d;
    logic [2:0]         fidx_q, fidx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               z_meta_q, z_s_q;
    logic               w_mismatch;
`ifdef GATE_EX_CONTINUE_EN
    logic [7:0]         err_q, err_d;
`endif

    // Response sampled against the truth-table bit for the current vector
    assign w_mismatch = z_s_q ^ EXPECT_MASK[vec_q];

    // Two-flop synchroniser: z0 comes from off-chip logic with no clock relation
    always_ff @(posedge clk) begin
        if (rst) begin
            z_meta_q <= 1'b0;
            z_s_q    <= 1'b0;
        end else begin
            z_meta_q <= z0;
            z_s_q    <= z_meta_q;
        end
    end

    // State and run-result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= 3'd0;
            fidx_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef GATE_EX_CONTINUE_EN
            err_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            fidx_q  <= fidx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
`ifdef GATE_EX_CONTINUE_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic: hold each vector, sample once, then advance or finish
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        fidx_d  = fidx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
`ifdef GATE_EX_CONTINUE_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE, S_FIN: begin
                // A finished run can be restarted directly from FIN
                if (start) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    vec_d   = 3'd0;
                    fidx_d  = 3'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
`ifdef GATE_EX_CONTINUE_EN
                    err_d   = 8'h00;
`endif
                end
            end
            S_HOLD: begin
                // Counter stops at its last value so it never exceeds SETTLE_CYCLES-1
                if (cnt_q == c_cnt_last) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
`ifdef GATE_EX_CONTINUE_EN
                if (w_mismatch) begin
                    err_d[vec_q] = 1'b1;
                    // Vectors run in ascending order, so the first hit is the lowest index
                    if (err_q == 8'h00) begin
                        fidx_d = vec_q;
                    end
                end
                if (vec_q == 3'd7) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 8'h00);
                end else begin
                    state_d = S_HOLD;
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = '0;
                end
`else
                if (w_mismatch) begin
                    // Stop at the first bad vector; no earlier mismatch can exist
                    state_d = S_FIN;
                    fidx_d  = vec_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end else if (vec_q == 3'd7) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else begin
                    state_d = S_HOLD;
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = '0;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stimulus is driven only while a run is active, otherwise parked at 0
    assign x0       = busy_q & vec_q[0];
    assign x1       = busy_q & vec_q[1];
    assign x2       = busy_q & vec_q[2];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign vec_idx  = vec_q;
    assign fail_idx = fidx_q;
`ifdef GATE_EX_CONTINUE_EN
    assign err_mask = err_q;
`else
    assign err_mask = 8'h00;
`endif

endmodule
`default_nettype wire
